// File: rtl/partition_sweep_checker_pkg.sv
// Shared types and sizing helpers for the exhaustive partition sweep checker.
`default_nettype none

package partition_sweep_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int LAT_MAX = 4;

    // Worst-case Hamming total is 2^IN_W * OUT_W.
    function automatic int ham_w(input int in_w, input int out_w);
        return in_w + $clog2(out_w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sweep_err_accum.sv
// Per-response comparison (mismatch, popcount, abs error) and result accumulators.
`default_nettype none

module sweep_err_accum
    import partition_sweep_checker_pkg::*;
#(
    parameter int IN_W  = 7,
    parameter int OUT_W = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr_i,
    input  logic                             en_i,
    input  logic [OUT_W-1:0]                 exact_i,
    input  logic [OUT_W-1:0]                 approx_i,
    output logic [IN_W:0]                    err_count_o,
    output logic [ham_w(IN_W, OUT_W)-1:0]    ham_sum_o,
    output logic [OUT_W-1:0]                 max_abs_err_o
);

    localparam int HAM_W = ham_w(IN_W, OUT_W);

    logic [OUT_W-1:0] diff_w;
    logic [HAM_W-1:0] pop_w;
    logic [OUT_W:0]   sub_w;
    logic [OUT_W-1:0] abs_w;

    logic [IN_W:0]    err_d, err_q;
    logic [HAM_W-1:0] ham_d, ham_q;
    logic [OUT_W-1:0] max_d, max_q;

    always_comb begin
        diff_w = exact_i ^ approx_i;
        pop_w  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            pop_w = pop_w + HAM_W'(diff_w[i]);
        end
        // The extra MSB of the difference is the borrow, i.e. the sign.
        sub_w = {1'b0, exact_i} - {1'b0, approx_i};
        abs_w = sub_w[OUT_W] ? (approx_i - exact_i) : sub_w[OUT_W-1:0];

        err_d = err_q;
        ham_d = ham_q;
        max_d = max_q;
        if (clr_i) begin
            err_d = '0;
            ham_d = '0;
            max_d = '0;
        end else if (en_i) begin
            if (diff_w != '0) begin
                err_d = err_q + (IN_W+1)'(1);
            end
            ham_d = ham_q + pop_w;
            if (abs_w > max_q) begin
                max_d = abs_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            ham_q <= '0;
            max_q <= '0;
        end else begin
            err_q <= err_d;
            ham_q <= ham_d;
            max_q <= max_d;
        end
    end

    assign err_count_o   = err_q;
    assign ham_sum_o     = ham_q;
    assign max_abs_err_o = max_q;

endmodule

`default_nettype wire

// File: rtl/partition_sweep_checker.sv
// Drives every input pattern into an exact and an approximate partition and
// accumulates how the approximate responses deviate from the exact ones.
`default_nettype none

module partition_sweep_checker
    import partition_sweep_checker_pkg::*;
#(
    parameter int IN_W  = 7,
    parameter int OUT_W = 4,
    parameter int LAT   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    output logic [IN_W-1:0]                  pattern,
    output logic                             pattern_vld,
    input  logic [OUT_W-1:0]                 exact_po,
    input  logic [OUT_W-1:0]                 approx_po,
    output logic                             busy,
    output logic                             done,
    output logic [IN_W:0]                    err_count,
    output logic [ham_w(IN_W, OUT_W)-1:0]    ham_sum,
    output logic [OUT_W-1:0]                 max_abs_err
);

    localparam int             DW           = $clog2(LAT_MAX);
    localparam logic [DW-1:0]  C_DRAIN_LAST = DW'((LAT > 0) ? (LAT - 1) : 0);

    state_e          state_q;
    logic [IN_W-1:0] pattern_q;
    logic            vld_q;
    logic            busy_q;
    logic            done_q;
    logic [DW-1:0]   drain_q;
    logic            dvld_w;
    logic            clr_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_SWEEP;
                        pattern_q <= '0;
                        vld_q     <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        vld_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (pattern_q == '1) begin
                        vld_q   <= 1'b0;
                        drain_q <= '0;
                        if (LAT == 0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else begin
                        pattern_q <= pattern_q + IN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (drain_q == C_DRAIN_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Delay the stimulus valid by LAT so it lines up with the partition response.
    generate
        if (LAT == 0) begin : g_lat_zero
            assign dvld_w = vld_q;
        end else begin : g_lat_pipe
            logic [LAT-1:0] vsr_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vsr_q <= '0;
                end else if (abort && (state_q == ST_SWEEP || state_q == ST_DRAIN)) begin
                    vsr_q <= '0;
                end else begin
                    vsr_q[0] <= vld_q;
                    for (int i = 1; i < LAT; i++) begin
                        vsr_q[i] <= vsr_q[i-1];
                    end
                end
            end
            assign dvld_w = vsr_q[LAT-1];
        end
    endgenerate

    assign clr_w = (state_q == ST_IDLE) && start;

    sweep_err_accum #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_accum (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_i         (clr_w),
        .en_i          (dvld_w),
        .exact_i       (exact_po),
        .approx_i      (approx_po),
        .err_count_o   (err_count),
        .ham_sum_o     (ham_sum),
        .max_abs_err_o (max_abs_err)
    );

    assign pattern     = pattern_q;
    assign pattern_vld = vld_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_partition_sweep_checker.sv
// Self-checking bench: one LAT=0 and one LAT=2 checker swept side by side.
`default_nettype none

module tb_partition_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    int         mode = 0;

    logic [6:0] pat0, pat2;
    logic       vld0, vld2, busy0, busy2, done0, done2;
    logic [3:0] exact0, approx0, exact2, approx2;
    logic [7:0] err0, err2;
    logic [9:0] ham0, ham2;
    logic [3:0] max0, max2;
    logic [3:0] e2_a, e2_b, a2_a, a2_b;

    int n_vec = 0;
    int n_miss = 0;
    int done_cnt0 = 0;
    int done_cnt2 = 0;

    typedef struct {
        int mode;
        int with_abort;
        int exp_err;
        int exp_ham;
        int exp_max;
    } vec_t;

    vec_t vecs[4];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [3:0] approx_f(input logic [3:0] e, input int m);
        case (m)
            0:       return e;
            1:       return e & 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    assign exact0  = pat0[3:0];
    assign approx0 = approx_f(pat0[3:0], mode);

    always @(posedge clk) begin
        e2_a <= pat2[3:0];
        e2_b <= e2_a;
        a2_a <= approx_f(pat2[3:0], mode);
        a2_b <= a2_a;
    end
    assign exact2  = e2_b;
    assign approx2 = a2_b;

    always @(posedge clk) begin
        if (done0) done_cnt0 <= done_cnt0 + 1;
        if (done2) done_cnt2 <= done_cnt2 + 1;
    end

    partition_sweep_checker #(.IN_W(7), .OUT_W(4), .LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pattern(pat0), .pattern_vld(vld0),
        .exact_po(exact0), .approx_po(approx0),
        .busy(busy0), .done(done0),
        .err_count(err0), .ham_sum(ham0), .max_abs_err(max0)
    );

    partition_sweep_checker #(.IN_W(7), .OUT_W(4), .LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pattern(pat2), .pattern_vld(vld2),
        .exact_po(exact2), .approx_po(approx2),
        .busy(busy2), .done(done2),
        .err_count(err2), .ham_sum(ham2), .max_abs_err(max2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_sweep(input vec_t v);
        vec_t e;
        int   done0_at, done2_at, nbusy0, nbusy2, seq_bad, d0_before, d2_before;
        done0_at = -1; done2_at = -1; nbusy0 = 0; nbusy2 = 0; seq_bad = 0;
        sb_q.push_back(v);
        @(negedge clk);
        mode  = v.mode;
        start = 1'b1;
        abort = (v.with_abort != 0);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        d0_before = done_cnt0;
        d2_before = done_cnt2;
        for (int j = 0; j < 400; j++) begin
            if (done0 && done0_at < 0) done0_at = j + 1;
            if (done2 && done2_at < 0) done2_at = j + 1;
            if (busy0) nbusy0++;
            if (busy2) nbusy2++;
            if (j < 128) begin
                if (!vld0 || pat0 != 7'(j)) seq_bad++;
            end else if (vld0) begin
                seq_bad++;
            end
            if (done2_at > 0 && done0_at > 0 && j >= done2_at + 3) break;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        chk("lat0_err_count", 32'(err0), 32'(e.exp_err));
        chk("lat0_ham_sum",   32'(ham0), 32'(e.exp_ham));
        chk("lat0_max_abs",   32'(max0), 32'(e.exp_max));
        chk("lat2_err_count", 32'(err2), 32'(e.exp_err));
        chk("lat2_ham_sum",   32'(ham2), 32'(e.exp_ham));
        chk("lat2_max_abs",   32'(max2), 32'(e.exp_max));
        chk("lat0_done_cycle", 32'(done0_at), 32'd129);
        chk("lat2_done_cycle", 32'(done2_at), 32'd131);
        chk("lat0_busy_cycles", 32'(nbusy0), 32'd128);
        chk("lat2_busy_cycles", 32'(nbusy2), 32'd130);
        chk("lat0_pattern_seq", 32'(seq_bad), 32'd0);
        chk("lat0_done_pulses", 32'(done_cnt0 - d0_before), 32'd1);
        chk("lat2_done_pulses", 32'(done_cnt2 - d2_before), 32'd1);
    endtask

    initial begin
        int d0_before, d2_before, exp0, exp2;

        vecs[0] = '{mode: 0, with_abort: 0, exp_err: 0,   exp_ham: 0,   exp_max: 0};
        vecs[1] = '{mode: 1, with_abort: 0, exp_err: 64,  exp_ham: 64,  exp_max: 1};
        vecs[2] = '{mode: 2, with_abort: 1, exp_err: 120, exp_ham: 256, exp_max: 15};
        vecs[3] = '{mode: 1, with_abort: 0, exp_err: 64,  exp_ham: 64,  exp_max: 1};

        #1 rst_n = 1'b0;
        #1;
        chk("reset_busy_done", {busy0, done0, busy2, done2, vld0, vld2}, 0);
        chk("reset_results", {err0, ham0, max0, err2, ham2, max2, pat0, pat2}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run_sweep(vecs[i]);
        end

        // Abort mid-sweep, with a start pulse that must be ignored.
        @(negedge clk);
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0_before = done_cnt0;
        d2_before = done_cnt2;
        repeat (19) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("no_restart_pattern", 32'(pat0), 32'd29);
        repeat (11) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_next", {busy0, vld0, busy2, vld2}, 0);
        // Odd patterns seen up to the abort cycle, less the LAT in flight.
        exp0 = 0; exp2 = 0;
        for (int p = 0; p <= 40; p++) if (p % 2 == 1) exp0++;
        for (int p = 0; p <= 38; p++) if (p % 2 == 1) exp2++;
        repeat (5) @(negedge clk);
        chk("abort_lat0_err_held", 32'(err0), 32'(exp0));
        chk("abort_lat2_err_held", 32'(err2), 32'(exp2));
        chk("abort_lat0_ham_held", 32'(ham0), 32'(exp0));
        chk("abort_no_done", 32'((done_cnt0 - d0_before) + (done_cnt2 - d2_before)), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_in_idle_noop", {24'(err0), 8'(busy0)}, {24'(exp0), 8'd0});

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_ctrl", {busy0, done0, vld0, busy2, done2, vld2}, 0);
        chk("midreset_lat0_results", {err0, ham0, max0, pat0}, 0);
        chk("midreset_lat2_results", {err2, ham2, max2, pat2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(vecs[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
